// File: rtl/state_sequencer.sv
// Control FSM that steps a bit-serial floating-point multiply-accumulate datapath through its phases.
// Optional abort input is compiled in only when SEQ_ABORT_EN is defined.
module state_sequencer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data_valid,
`ifdef SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic [3:0] state_ctrl,
  output logic [4:0] bit_idx,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE               = 4'b0000,
    STORE_DATA         = 4'b0001,
    EXP_ADD_CS         = 4'b0010,
    EXP_ADD_BITWISE    = 4'b0011,
    STORE_EMAX         = 4'b0100,
    EMAX_OUTPUT_ADD    = 4'b0101,
    FIND_EXP_BIT       = 4'b0110,
    SHIFT_MANTISSA     = 4'b0111,
    PARTIAL_MUL        = 4'b1000,
    PARTIAL_SUM_OUTPUT = 4'b1001,
    DONE               = 4'b1111
  } state_t;

  localparam logic [4:0] EXP_LAST = 5'(EXP_W);
  localparam logic [4:0] MAN_LAST = 5'(MAN_W - 1);

  state_t     state;
  state_t     next_state;
  logic [4:0] next_idx;

  // Exponent phases run EXP_W+1 steps; mantissa phases run MAN_W two-state pairs sharing one index.
  always_comb begin
    next_state = IDLE;
    next_idx   = '0;
    case (state)
      IDLE:            next_state = start ? STORE_DATA : IDLE;
      STORE_DATA:      next_state = data_valid ? EXP_ADD_CS : STORE_DATA;
      EXP_ADD_CS:      next_state = EXP_ADD_BITWISE;
      EXP_ADD_BITWISE: begin
        if (bit_idx == EXP_LAST) begin
          next_state = STORE_EMAX;
        end else begin
          next_state = EXP_ADD_BITWISE;
          next_idx   = bit_idx + 5'd1;
        end
      end
      STORE_EMAX:      next_state = EMAX_OUTPUT_ADD;
      EMAX_OUTPUT_ADD: begin
        if (bit_idx == EXP_LAST) begin
          next_state = FIND_EXP_BIT;
        end else begin
          next_state = EMAX_OUTPUT_ADD;
          next_idx   = bit_idx + 5'd1;
        end
      end
      FIND_EXP_BIT: begin
        next_state = SHIFT_MANTISSA;
        next_idx   = bit_idx;
      end
      SHIFT_MANTISSA: begin
        if (bit_idx == MAN_LAST) begin
          next_state = PARTIAL_MUL;
        end else begin
          next_state = FIND_EXP_BIT;
          next_idx   = bit_idx + 5'd1;
        end
      end
      PARTIAL_MUL: begin
        next_state = PARTIAL_SUM_OUTPUT;
        next_idx   = bit_idx;
      end
      PARTIAL_SUM_OUTPUT: begin
        if (bit_idx == MAN_LAST) begin
          next_state = DONE;
        end else begin
          next_state = PARTIAL_MUL;
          next_idx   = bit_idx + 5'd1;
        end
      end
      DONE:            next_state = IDLE;
      default:         next_state = IDLE;
    endcase
`ifdef SEQ_ABORT_EN
    if (abort) begin
      next_state = IDLE;
      next_idx   = '0;
    end
`endif
  end

  // busy is registered from the next state so it lines up exactly with state_ctrl.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state;
      bit_idx <= next_idx;
      busy    <= (next_state != IDLE);
    end
  end

  assign state_ctrl = state;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed testbench for state_sequencer; define SEQ_ABORT_EN to also exercise the abort path.
module tb_state_sequencer;

  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_STORE = 4'b0001;
  localparam logic [3:0] S_CS    = 4'b0010;
  localparam logic [3:0] S_BW    = 4'b0011;
  localparam logic [3:0] S_EMAX  = 4'b0100;
  localparam logic [3:0] S_EOA   = 4'b0101;
  localparam logic [3:0] S_FIND  = 4'b0110;
  localparam logic [3:0] S_SHIFT = 4'b0111;
  localparam logic [3:0] S_PMUL  = 4'b1000;
  localparam logic [3:0] S_PSUM  = 4'b1001;
  localparam logic [3:0] S_DONE  = 4'b1111;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] idx;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       data_valid;
`ifdef SEQ_ABORT_EN
  logic       abort;
`endif
  logic [3:0] state_ctrl;
  logic [4:0] bit_idx;
  logic       busy;

  int    checks   = 0;
  int    failures = 0;
  step_t exp_q[$];

  state_sequencer #(.EXP_W(8), .MAN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_valid (data_valid),
`ifdef SEQ_ABORT_EN
    .abort      (abort),
`endif
    .state_ctrl (state_ctrl),
    .bit_idx    (bit_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Hand-written phase list for EXP_W=MAN_W=8; stall adds extra STORE_DATA cycles.
  function automatic void build_expected(input int stall);
    exp_q.delete();
    for (int i = 0; i <= stall; i++) exp_q.push_back({S_STORE, 5'd0});
    exp_q.push_back({S_CS, 5'd0});
    for (int i = 0; i <= 8; i++) exp_q.push_back({S_BW, 5'(i)});
    exp_q.push_back({S_EMAX, 5'd0});
    for (int i = 0; i <= 8; i++) exp_q.push_back({S_EOA, 5'(i)});
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({S_FIND, 5'(i)});
      exp_q.push_back({S_SHIFT, 5'(i)});
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({S_PMUL, 5'(i)});
      exp_q.push_back({S_PSUM, 5'(i)});
    end
    exp_q.push_back({S_DONE, 5'd0});
  endfunction

  task automatic test_reset;
    #1;
    checks++;
    if (state_ctrl !== S_IDLE || bit_idx !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async: got %b/%0d/%b want 0000/0/0", state_ctrl, bit_idx, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (state_ctrl !== S_IDLE || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_idle: got %b/%b want 0000/0", state_ctrl, busy);
    end
  endtask

  task automatic test_nominal(input string tag);
    build_expected(0);
    start      = 1'b1;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (state_ctrl !== exp_q[j].st) begin
        failures++;
        $display("[TB] FAIL %s_state j=%0d: got %b want %b", tag, j, state_ctrl, exp_q[j].st);
      end
      checks++;
      if (bit_idx !== exp_q[j].idx) begin
        failures++;
        $display("[TB] FAIL %s_idx j=%0d: got %0d want %0d", tag, j, bit_idx, exp_q[j].idx);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s_busy j=%0d: got %b want 1", tag, j, busy);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (state_ctrl !== S_IDLE || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_end_idle: got %b/%b want 0000/0", tag, state_ctrl, busy);
    end
    data_valid = 1'b0;
  endtask

  task automatic test_stall;
    build_expected(5);
    start      = 1'b1;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (state_ctrl !== exp_q[j].st || bit_idx !== exp_q[j].idx) begin
        failures++;
        $display("[TB] FAIL stall_step j=%0d: got %b/%0d want %b/%0d",
                 j, state_ctrl, bit_idx, exp_q[j].st, exp_q[j].idx);
      end
      data_valid = (j >= 5);
      @(posedge clk);
      #1;
    end
    checks++;
    if (state_ctrl !== S_IDLE || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_end_idle: got %b/%b want 0000/0", state_ctrl, busy);
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    start      = 1'b1;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (state_ctrl !== S_EOA || bit_idx !== 5'd4) begin
      failures++;
      $display("[TB] FAIL midrun_position: got %b/%0d want 0101/4", state_ctrl, bit_idx);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state_ctrl !== S_IDLE || bit_idx !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_async_clear: got %b/%0d/%b want 0000/0/0", state_ctrl, bit_idx, busy);
    end
    @(posedge clk);
    #1;
    rst        = 1'b0;
    data_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if (state_ctrl !== S_IDLE || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midrun_stay_idle j=%0d: got %b/%b want 0000/0", j, state_ctrl, busy);
      end
    end
    test_nominal("after_reset");
  endtask

  task automatic test_ignored_start;
    build_expected(0);
    start      = 1'b1;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < exp_q.size(); j++) begin
      checks++;
      if (state_ctrl !== exp_q[j].st || bit_idx !== exp_q[j].idx) begin
        failures++;
        $display("[TB] FAIL held_start_step j=%0d: got %b/%0d want %b/%0d",
                 j, state_ctrl, bit_idx, exp_q[j].st, exp_q[j].idx);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (state_ctrl !== S_IDLE || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL held_start_idle: got %b/%b want 0000/0", state_ctrl, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state_ctrl !== S_STORE || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL held_start_restart: got %b/%b want 0001/1", state_ctrl, busy);
    end
    start      = 1'b0;
    data_valid = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (state_ctrl !== S_IDLE) begin
      failures++;
      $display("[TB] FAIL held_start_cleanup: got %b want 0000", state_ctrl);
    end
  endtask

`ifdef SEQ_ABORT_EN
  task automatic test_abort;
    start      = 1'b1;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (37) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (state_ctrl !== S_PMUL || bit_idx !== 5'd0) begin
      failures++;
      $display("[TB] FAIL abort_position: got %b/%0d want 1000/0", state_ctrl, bit_idx);
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort      = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    checks++;
    if (state_ctrl !== S_IDLE || bit_idx !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_to_idle: got %b/%0d/%b want 0000/0/0", state_ctrl, bit_idx, busy);
    end
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if (state_ctrl !== S_IDLE) begin
        failures++;
        $display("[TB] FAIL abort_no_done j=%0d: got %b want 0000", j, state_ctrl);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
`ifdef SEQ_ABORT_EN
    abort      = 1'b0;
`endif
    #2;
    rst = 1'b1;
    test_reset();
    test_nominal("nominal");
    test_stall();
    test_reset_mid_run();
    test_ignored_start();
`ifdef SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
